stego_lsb_extractor: RTL and testbench

Recovers a hidden message from a stego image stream by XORing the 3 LSBs of each stego pixel byte with the matching cover pixel byte. It repacks the recovered 3-bit chunks into message bytes, LSB first, and hands them out over a valid/ready port. It sits directly downstream of the LSB embedding stage and is the inverse of its packing and embedding steps: chunk c carries message bits 3c, 3c+1 and 3c+2 in pixel-byte bits [0], [1] and [2].

---
 rtl/stego_lsb_extractor.sv | 100 ++++++++++
 tb/tb_stego_lsb_extractor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stego_lsb_extractor.sv
// stego_lsb_extractor: recovers message bytes from stego^cover pixel LSBs, packed LSB first.
// Optional XOR checksum of emitted bytes when STEGO_EXTRACT_CHECKSUM_EN is defined.
module stego_lsb_extractor #(
  parameter int MSG_LEN = 3
) (
  input  logic       clk,
  input  logic       HRESET,
  input  logic       start,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] stego_byte,
  input  logic [7:0] cover_byte,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_byte,
  output logic       busy,
  output logic       done,
  output logic [7:0] chk_byte
);
  localparam int TOT = MSG_LEN * 8;
  localparam int BW = $clog2(TOT + 1);
  localparam logic [BW-1:0] TOT_B = BW'(TOT);
  localparam logic [7:0] LEN_B = 8'(MSG_LEN);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state_q, state_d;
  logic [9:0] acc_q, acc_d;
  logic [3:0] acc_cnt_q, acc_cnt_d;
  logic [BW-1:0] bits_taken_q, bits_taken_d, rem;
  logic [7:0] bytes_out_q, bytes_out_d;
  logic [1:0] n;
  logic [2:0] dm;
  logic pix_fire, msg_fire;
  always_comb begin
    rem = TOT_B - bits_taken_q;
    n = (rem >= BW'(3)) ? 2'd3 : rem[1:0];
    dm = (stego_byte[2:0] ^ cover_byte[2:0]) & ((n == 2'd3) ? 3'b111 : (n == 2'd2) ? 3'b011 : (n == 2'd1) ? 3'b001 : 3'b000);
    pix_ready = (state_q == COLLECT) && (acc_cnt_q < 4'd8) && (bits_taken_q < TOT_B);
    msg_valid = (state_q == COLLECT) && (acc_cnt_q >= 4'd8);
    msg_byte = acc_q[7:0];
    busy = state_q == COLLECT;
    done = state_q == DONE;
    pix_fire = pix_valid && pix_ready;
    msg_fire = msg_valid && msg_ready;
    state_d = state_q;
    acc_d = acc_q;
    acc_cnt_d = acc_cnt_q;
    bits_taken_d = bits_taken_q;
    bytes_out_d = bytes_out_q;
    if (state_q == IDLE && start) begin
      acc_d = '0;
      acc_cnt_d = '0;
      bits_taken_d = '0;
      bytes_out_d = '0;
      state_d = COLLECT;
    end else if (state_q == COLLECT) begin
      if (pix_fire) begin
        acc_d = acc_q | (10'(dm) << acc_cnt_q);
        acc_cnt_d = acc_cnt_q + 4'(n);
        bits_taken_d = bits_taken_q + BW'(n);
      end else if (msg_fire) begin
        acc_d = {8'b0, acc_q[9:8]};
        acc_cnt_d = acc_cnt_q - 4'd8;
        bytes_out_d = bytes_out_q + 8'd1;
        state_d = (bytes_out_q + 8'd1 == LEN_B) ? DONE : COLLECT;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (HRESET) begin
      state_q <= IDLE;
      acc_q <= '0;
      acc_cnt_q <= '0;
      bits_taken_q <= '0;
      bytes_out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      bits_taken_q <= bits_taken_d;
      bytes_out_q <= bytes_out_d;
    end
  end
`ifdef STEGO_EXTRACT_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE && start) chk_d = '0;
    else if (msg_fire) chk_d = chk_q ^ acc_q[7:0];
    chk_byte = chk_q;
  end
  always_ff @(posedge clk) begin
    if (HRESET) chk_q <= '0;
    else chk_q <= chk_d;
  end
`else
  assign chk_byte = 8'h00;
`endif
endmodule

// File: tb/tb_stego_lsb_extractor.sv
// tb_stego_lsb_extractor: randomized and directed checks against a bit-stream message model.
module tb_stego_lsb_extractor;
  logic clk = 0, HRESET = 1, start = 0, pix_valid = 0, msg_ready = 0;
  logic [7:0] stego_byte = 0, cover_byte = 0;
  logic pix_ready, msg_valid, busy, done;
  logic [7:0] msg_byte, chk_byte;
  logic start1 = 0, pv1 = 0, mr1 = 0;
  logic [7:0] sb1 = 0, cb1 = 0;
  logic pr1, mv1, busy1, done1;
  logic [7:0] mb1, chk1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  stego_lsb_extractor #(.MSG_LEN(3)) u_dut (
    .clk(clk), .HRESET(HRESET), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .stego_byte(stego_byte), .cover_byte(cover_byte), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_byte(msg_byte), .busy(busy), .done(done), .chk_byte(chk_byte));

  stego_lsb_extractor #(.MSG_LEN(1)) u_dut1 (
    .clk(clk), .HRESET(HRESET), .start(start1), .pix_valid(pv1), .pix_ready(pr1),
    .stego_byte(sb1), .cover_byte(cb1), .msg_valid(mv1), .msg_ready(mr1),
    .msg_byte(mb1), .busy(busy1), .done(done1), .chk_byte(chk1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready/valid, 1: random handshakes and stray starts, 2: 5-cycle stall on first byte
  task automatic run3(input logic [23:0] msg, input bit fixed, input logic [7:0] cov, input int mode);
    int pi = 0, oi = 0, bp = 0, cyc = 0, it = 0, extra = 0;
    logic [2:0] chunks [9];
    logic [7:0] cx, ck = 0;
    for (int c = 0; c < 8; c++) chunks[c] = msg[c*3 +: 3];
    chunks[8] = 3'($urandom);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", pix_ready, 1);
    while (oi < 3 && it < 400) begin
      it++;
      if (busy) cyc++;
      pix_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1) start = 1'($urandom_range(0, 1));
      if (mode == 2 && oi == 0 && msg_valid && bp < 5) begin
        msg_ready = 0;
        bp++;
        check("bp_hold_byte", msg_byte, msg[7:0]);
        check("bp_valid", msg_valid, 1);
        check("bp_no_pix", pix_ready, 0);
      end
      cx = fixed ? cov : 8'($urandom);
      cover_byte = cx;
      stego_byte = {(fixed ? cx[7:3] : 5'($urandom)), cx[2:0] ^ chunks[(pi < 8) ? pi : 8]};
      if (pix_valid && pix_ready) begin
        if (pi < 8) pi++;
        else extra++;
      end
      if (msg_valid && msg_ready) begin
        check($sformatf("msg%0d", oi), msg_byte, msg[oi*8 +: 8]);
        ck ^= msg[oi*8 +: 8];
        oi++;
      end
      @(negedge clk);
    end
    start = 0;
    pix_valid = 1;
    msg_ready = 1;
    check("timeout", it < 400, 1);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("ready_in_done", pix_ready, 0);
    check("valid_in_done", msg_valid, 0);
    check("pix_count", pi, 8);
    check("extra_pix", extra, 0);
    if (mode == 0) check("busy_cycles", cyc, 11);
`ifdef STEGO_EXTRACT_CHECKSUM_EN
    check("chk", chk_byte, ck);
`else
    check("chk", chk_byte, 0);
`endif
    @(negedge clk);
    check("done_drop", done, 0);
    check("idle_ready", pix_ready, 0);
    pix_valid = 0;
  endtask

  task automatic run1(input logic [7:0] m, input logic junk);
    int pi = 0, it = 0, extra = 0;
    bit got = 0;
    logic [2:0] ch;
    logic [7:0] cx;
    @(negedge clk); start1 = 1;
    @(negedge clk); start1 = 0;
    while (!got && it < 100) begin
      it++;
      ch = (pi == 0) ? m[2:0] : (pi == 1) ? m[5:3] : {junk, m[7:6]};
      cx = 8'($urandom);
      cb1 = cx;
      sb1 = {cx[7:3], cx[2:0] ^ ch};
      pv1 = 1;
      mr1 = 1;
      if (pr1) begin
        if (pi < 3) pi++;
        else extra++;
      end
      if (mv1) begin
        check("len1_byte", mb1, m);
        check("len1_no_4th", pr1, 0);
        got = 1;
      end
      @(negedge clk);
    end
    check("len1_timeout", it < 100, 1);
    check("len1_done", done1, 1);
    check("len1_pix_count", pi, 3);
    check("len1_extra", extra, 0);
    @(negedge clk);
    check("len1_after_done", pr1, 0);
    pv1 = 0;
  endtask

  initial begin
    int k, it;
    repeat (3) @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_msg_valid", msg_valid, 0);
    check("rst_msg_byte", msg_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chk", chk_byte, 0);
    HRESET = 0;
    pix_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_pix_ready", pix_ready, 0);
      check("idle_busy", busy, 0);
    end
    pix_valid = 0;
    run3(24'h434241, 1, 8'h80, 0);
    run3(24'h434241, 1, 8'h57, 0);
    run3(24'h434241, 1, 8'h80, 2);
    run1(8'hFF, 1);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    pix_valid = 1; msg_ready = 1; cover_byte = 8'h80; stego_byte = 8'h81;
    k = 0; it = 0;
    while (k < 4 && it < 50) begin
      it++;
      if (pix_ready) k++;
      @(negedge clk);
    end
    check("rst_mid_reached", k, 4);
    HRESET = 1;
    @(negedge clk);
    check("mid_rst_pix_ready", pix_ready, 0);
    check("mid_rst_msg_valid", msg_valid, 0);
    check("mid_rst_msg_byte", msg_byte, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_chk", chk_byte, 0);
    HRESET = 0;
    pix_valid = 0;
    run3(24'h434241, 1, 8'h80, 0);
    repeat (20) run3(24'($urandom), 0, 8'h00, 1);
    repeat (10) run1(8'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
